// File: rtl/tt_pin_responder_pkg.sv
// Shared types and constants for the pin-level REQ/ACK register responder.
// Pin indices refer to bit positions inside uio_in / uio_out.
package tt_pin_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int NUM_SCRATCH = 6;

    localparam logic [2:0] ADDR_CNT = 3'd6;
    localparam logic [2:0] ADDR_ID  = 3'd7;

    localparam int PIN_REQ     = 0;
    localparam int PIN_WE      = 1;
    localparam int PIN_ADDR_LO = 2;
    localparam int PIN_ACK     = 5;
    localparam int PIN_ERR     = 6;
    localparam int PIN_PAR     = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hE0;

endpackage

// File: rtl/tt_sync_ff.sv
// N-stage flop-chain synchronizer for a single asynchronous level input.
// Synchronous active-high reset clears every stage.
module tt_sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/tt_pin_responder.sv
// Pin-level register responder: 4-phase REQ/ACK handshake into six scratch
// registers, a transaction counter (addr 6) and a constant ID byte (addr 7).
//
// Handshake: the host drives ADDR/WE/data stable, then raises REQ; the
// responder completes exactly one access and raises ACK; the host drops REQ
// and the responder drops ACK, after which the next REQ may be raised.
module tt_pin_responder
    import tt_pin_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t     state_q, state_d;
    logic       req_s;
    logic [2:0] addr_q, addr_d;
    logic       we_q, we_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] regs_q [NUM_SCRATCH];
    logic [7:0] regs_d [NUM_SCRATCH];
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    logic       unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:5]};

    tt_sync_ff #(.N(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (uio_in[PIN_REQ]),
        .q   (req_s)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        regs_d  = regs_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // Command pins are held stable by the host, so they are taken raw.
                if (req_s && ena) begin
                    state_d = EXEC;
                    addr_d  = uio_in[PIN_ADDR_LO +: 3];
                    we_d    = uio_in[PIN_WE];
                    wdata_d = ui_in;
                end
            end
            EXEC: begin
                state_d = ACK;
                ack_d   = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (we_q) begin
                    if (addr_q < ADDR_CNT) begin
                        regs_d[addr_q] = wdata_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    case (addr_q)
                        ADDR_CNT: rdata_d = cnt_q;
                        ADDR_ID: begin
                            rdata_d = ID_VALUE;
                            err_d   = 1'b0;
                        end
                        default:  rdata_d = regs_q[addr_q];
                    endcase
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            regs_q  <= '{default: '0};
            cnt_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            regs_q  <= regs_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        uio_out          = '0;
        uio_out[PIN_ACK] = ack_q;
        uio_out[PIN_ERR] = err_q;
        uio_out[PIN_PAR] = ^rdata_q;
    end

    assign uo_out = rdata_q;
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_pin_responder.sv
// Directed bench for tt_pin_responder: a host-side driver, a behavioural
// register model feeding an expected queue, and a one-line summary.
module tb_tt_pin_responder;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_bad = 0;

    // expected {err, uo_out} for each issued transaction
    logic [8:0] exp_q [$];

    logic [7:0] m_regs [6];
    logic [7:0] m_cnt;
    logic [7:0] m_uo;
    logic       m_err;

    tt_pin_responder #(.SYNC_STAGES(2), .ID_VALUE(8'h5A)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_regs[i] = 8'h00;
        m_cnt = 8'h00;
        m_uo  = 8'h00;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic we, input logic [2:0] addr, input logic [7:0] data);
        if (we) begin
            if (addr < 3'd6) m_regs[addr] = data;
            else m_err = 1'b1;
        end else begin
            if (addr < 3'd6) m_uo = m_regs[addr];
            else if (addr == 3'd6) m_uo = m_cnt;
            else begin
                m_uo  = 8'h5A;
                m_err = 1'b0;
            end
        end
        m_cnt = m_cnt + 8'd1;
        exp_q.push_back({m_err, m_uo});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        uio_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_result(input string tag);
        logic [8:0] e;
        e = exp_q.pop_front();
        check({tag, "_uo"}, {8'h00, uo_out}, {8'h00, e[7:0]});
        check({tag, "_err"}, {15'h0, uio_out[6]}, {15'h0, e[8]});
        check({tag, "_par"}, {15'h0, uio_out[7]}, {15'h0, ^e[7:0]});
    endtask

    // Waits (bounded) until ACK equals level; returns number of posedges seen.
    task automatic wait_ack(input logic level, output int n, output bit got);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (uio_out[5] === level) got = 1'b1;
        end
    endtask

    task automatic run_txn(input logic we, input logic [2:0] addr, input logic [7:0] data,
                           input bit chk_timing, input string tag);
        int n;
        bit got;
        model_push(we, addr, data);
        @(negedge clk);
        uio_in = {3'b000, addr, we, 1'b0};
        ui_in  = data;
        @(negedge clk);
        uio_in[0] = 1'b1;
        wait_ack(1'b1, n, got);
        if (!got) check({tag, "_ack_rise_timeout"}, 16'(got), 16'd1);
        if (chk_timing) check({tag, "_ack_rise_edges"}, 16'(n), 16'd4);
        check_result(tag);
        uio_in[0] = 1'b0;
        wait_ack(1'b0, n, got);
        if (!got) check({tag, "_ack_fall_timeout"}, 16'(got), 16'd1);
        if (chk_timing) check({tag, "_ack_fall_edges"}, 16'(n), 16'd3);
    endtask

    initial begin
        int n;
        bit got;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();

        // Reset values
        do_reset();
        check("rst_uo_out", {8'h00, uo_out}, 16'h0000);
        check("rst_uio_out", {8'h00, uio_out}, 16'h0000);
        check("rst_uio_oe", {8'h00, uio_oe}, 16'h00E0);
        run_txn(1'b0, 3'd6, 8'h00, 1'b1, "rst_cnt_read");

        // Write / read back with handshake timing
        run_txn(1'b1, 3'd2, 8'h3C, 1'b1, "wr_a2");
        run_txn(1'b0, 3'd2, 8'h00, 1'b1, "rd_a2");
        run_txn(1'b1, 3'd5, 8'hA7, 1'b0, "wr_a5");
        run_txn(1'b1, 3'd0, 8'h01, 1'b0, "wr_a0");
        run_txn(1'b0, 3'd5, 8'h00, 1'b0, "rd_a5");
        run_txn(1'b0, 3'd0, 8'h00, 1'b0, "rd_a0");
        for (int i = 0; i < 4; i++) begin
            logic [2:0] a;
            logic [7:0] d;
            a = 3'($urandom_range(0, 5));
            d = 8'($urandom_range(0, 255));
            run_txn(1'b1, a, d, 1'b0, "rnd_wr");
            run_txn(1'b0, a, 8'h00, 1'b0, "rnd_rd");
        end

        // Read-only protection and sticky error
        run_txn(1'b1, 3'd7, 8'h00, 1'b0, "wr_id_err");
        run_txn(1'b0, 3'd1, 8'h00, 1'b0, "err_sticky");
        run_txn(1'b0, 3'd7, 8'h00, 1'b0, "rd_id_clr");
        run_txn(1'b1, 3'd6, 8'hFF, 1'b0, "wr_cnt_err");
        run_txn(1'b0, 3'd6, 8'h00, 1'b0, "rd_cnt_after_err");
        run_txn(1'b0, 3'd7, 8'h00, 1'b0, "rd_id_clr2");

        // Counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) run_txn(1'b0, 3'd0, 8'h00, 1'b0, "wrap_fill");
        run_txn(1'b0, 3'd6, 8'h00, 1'b0, "cnt_ff");
        run_txn(1'b0, 3'd6, 8'h00, 1'b0, "cnt_wrap");

        // Reset in the middle of a transaction
        run_txn(1'b1, 3'd2, 8'h77, 1'b0, "wr_a2_pre");
        @(negedge clk);
        uio_in = {3'b000, 3'd2, 1'b0, 1'b0};
        @(negedge clk);
        uio_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ack", {15'h0, uio_out[5]}, 16'h0000);
        check("midrst_uo", {8'h00, uo_out}, 16'h0000);
        rst    = 1'b0;
        uio_in = 8'h00;
        model_reset();
        run_txn(1'b0, 3'd2, 8'h00, 1'b0, "midrst_a2_clear");

        // ena gating
        model_push(1'b0, 3'd6, 8'h00);
        @(negedge clk);
        ena    = 1'b0;
        uio_in = {3'b000, 3'd6, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("ena_low_ack", {15'h0, uio_out[5]}, 16'h0000);
        end
        ena = 1'b1;
        wait_ack(1'b1, n, got);
        check("ena_ack_seen", 16'(got), 16'd1);
        check("ena_ack_within2", 16'(n <= 2), 16'd1);
        check_result("ena_rd_cnt");
        uio_in[0] = 1'b0;
        wait_ack(1'b0, n, got);
        check("ena_ack_fall", 16'(got), 16'd1);

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
